// File: rtl/alu_exec_if.sv
// Operand/result bundle between the ALU control stage and the execute stage.
// The issuing side drives the request, the execute stage drives results and status.
interface alu_exec_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [3:0]       ALUC;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             busy;
   logic             done;

   modport master (
      output start, ALUC, A, B,
      input  result, zero, hi, lo, busy, done
   );

   modport slave (
      input  start, ALUC, A, B,
      output result, zero, hi, lo, busy, done
   );
endinterface

// File: rtl/alu_exec.sv
// MIPS execute stage: single-cycle logic/arithmetic ops with a registered result,
// plus a signed multiply built from an iterative shift-add on operand magnitudes.
module alu_exec #(
   parameter int WIDTH = 32,
   parameter int ITER  = WIDTH
) (
   input  logic      clk,
   input  logic      rst,
   alu_exec_if.slave bus
);

   typedef enum logic {IDLE, MUL} state_t;

   localparam int CW = $clog2(ITER + 1);

   localparam logic [3:0] OpAnd  = 4'b0000;
   localparam logic [3:0] OpOr   = 4'b0011;
   localparam logic [3:0] OpAdd  = 4'b0100;
   localparam logic [3:0] OpSub  = 4'b0101;
   localparam logic [3:0] OpSlt  = 4'b0111;
   localparam logic [3:0] OpMult = 4'b1010;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               zero_q, zero_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               done_q, done_d;
   logic               sign_q, sign_d;
   logic [CW-1:0]      count_q, count_d;
   logic [2*WIDTH-1:0] accum_q, accum_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;

   logic [WIDTH-1:0]   aluResult;
   logic [WIDTH-1:0]   magA;
   logic [WIDTH-1:0]   magB;
   logic [2*WIDTH-1:0] partialSum;
   logic [2*WIDTH-1:0] product;

   // Single-cycle datapath; undefined codes yield zero.
   always_comb begin
      aluResult = '0;
      case (bus.ALUC)
         OpAnd:   aluResult = bus.A & bus.B;
         OpOr:    aluResult = bus.A | bus.B;
         OpAdd:   aluResult = bus.A + bus.B;
         OpSub:   aluResult = bus.A - bus.B;
         OpSlt:   aluResult = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
         default: aluResult = '0;
      endcase
   end

   // The most negative value negates to itself, which is its correct unsigned magnitude.
   assign magA       = bus.A[WIDTH-1] ? -bus.A : bus.A;
   assign magB       = bus.B[WIDTH-1] ? -bus.B : bus.B;
   assign partialSum = accum_q + (mplier_q[0] ? mcand_q : '0);
   assign product    = sign_q ? -partialSum : partialSum;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         result_q <= '0;
         zero_q   <= 1'b1;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
         sign_q   <= 1'b0;
         count_q  <= '0;
         accum_q  <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         done_q   <= done_d;
         sign_q   <= sign_d;
         count_q  <= count_d;
         accum_q  <= accum_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
      end
   end

   // Requests are only accepted in IDLE, so a start during MUL is simply dropped.
   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      zero_d   = zero_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;
      sign_d   = sign_q;
      count_d  = count_q;
      accum_d  = accum_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (bus.ALUC == OpMult) begin
                  mcand_d  = {{WIDTH{1'b0}}, magA};
                  mplier_d = magB;
                  sign_d   = bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
                  accum_d  = '0;
                  count_d  = CW'(ITER);
                  state_d  = MUL;
               end else begin
                  result_d = aluResult;
                  zero_d   = (aluResult == '0);
                  done_d   = 1'b1;
               end
            end
         end
         MUL: begin
            accum_d  = partialSum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q - CW'(1);
            if (count_q == CW'(1)) begin
               {hi_d, lo_d} = product;
               done_d       = 1'b1;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.result = result_q;
   assign bus.zero   = zero_q;
   assign bus.hi     = hi_q;
   assign bus.lo     = lo_q;
   assign bus.busy   = (state_q == MUL);
   assign bus.done   = done_q;

endmodule

// File: tb/tb_alu_exec.sv
// Randomized self-checking bench for alu_exec; expected values come from plain
// arithmetic on the operation codes, including a 64-bit signed product for MULT.
module tb_alu_exec;

   localparam int WIDTH = 32;
   localparam int ITER  = 32;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   logic [WIDTH-1:0] expResult;
   logic             expZero;
   logic [WIDTH-1:0] expHi;
   logic [WIDTH-1:0] expLo;

   alu_exec_if #(.WIDTH(WIDTH)) bus ();

   alu_exec #(.WIDTH(WIDTH), .ITER(ITER)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Every comparison funnels through here so the counters stay honest.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [WIDTH-1:0] refAlu(input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      longint sa;
      longint sb;
      longint sum;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         4'b0000: return a & b;
         4'b0011: return a | b;
         4'b0100: begin sum = sa + sb; return sum[WIDTH-1:0]; end
         4'b0101: begin sum = sa - sb; return sum[WIDTH-1:0]; end
         4'b0111: return (sa < sb) ? 1 : 0;
         default: return '0;
      endcase
   endfunction

   // Issue a single-cycle op; afterwards the bench sits in the cycle where done is high.
   task automatic applyStimulus(input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      bus.start = 1'b1;
      bus.ALUC  = op;
      bus.A     = a;
      bus.B     = b;
      tick();
      bus.start = 1'b0;
      expResult = refAlu(op, a, b);
      expZero   = (expResult == '0);
      checkOutput("single.done",   64'(bus.done),   64'(1));
      checkOutput("single.busy",   64'(bus.busy),   64'(0));
      checkOutput("single.result", 64'(bus.result), 64'(expResult));
      checkOutput("single.zero",   64'(bus.zero),   64'(expZero));
      checkOutput("single.hilo",   {bus.hi, bus.lo}, {expHi, expLo});
   endtask

   task automatic idleCycle();
      tick();
      checkOutput("idle.done", 64'(bus.done), 64'(0));
   endtask

   // MULT with optional ignored start at injectAt and reset at abortAt (-1 disables).
   task automatic runMult(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int injectAt, input int abortAt);
      longint p;
      int     busyCycles;
      int     earlyDone;
      p          = longint'($signed(a)) * longint'($signed(b));
      busyCycles = 0;
      earlyDone  = 0;
      bus.start  = 1'b1;
      bus.ALUC   = 4'b1010;
      bus.A      = a;
      bus.B      = b;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < ITER; i++) begin
         if (bus.busy) busyCycles++;
         if (bus.done) earlyDone++;
         bus.A     = $urandom;
         bus.B     = $urandom;
         bus.start = (i == injectAt);
         bus.ALUC  = (i == injectAt) ? 4'b0100 : 4'b1010;
         if (i == abortAt) begin
            rst = 1'b1;
            tick();
            rst       = 1'b0;
            bus.start = 1'b0;
            expResult = '0;
            expZero   = 1'b1;
            expHi     = '0;
            expLo     = '0;
            checkOutput("abort.busy",   64'(bus.busy), 64'(0));
            checkOutput("abort.done",   64'(bus.done), 64'(0));
            checkOutput("abort.hilo",   {bus.hi, bus.lo}, 64'(0));
            checkOutput("abort.result", 64'(bus.result), 64'(0));
            checkOutput("abort.early",  64'(earlyDone), 64'(0));
            return;
         end
         tick();
      end
      bus.start = 1'b0;
      expHi = p[63:32];
      expLo = p[31:0];
      checkOutput("mult.busyCycles", 64'(busyCycles), 64'(ITER));
      checkOutput("mult.earlyDone",  64'(earlyDone),  64'(0));
      checkOutput("mult.done",       64'(bus.done),   64'(1));
      checkOutput("mult.busy",       64'(bus.busy),   64'(0));
      checkOutput("mult.hilo",       {bus.hi, bus.lo}, {expHi, expLo});
      checkOutput("mult.result",     64'(bus.result), 64'(expResult));
      checkOutput("mult.zero",       64'(bus.zero),   64'(expZero));
   endtask

   logic [3:0] opTable [8];
   logic [3:0] op;

   initial begin
      checks    = 0;
      errors    = 0;
      opTable   = '{4'b0000, 4'b0011, 4'b0100, 4'b0101, 4'b0111, 4'b1010, 4'b1111, 4'b0110};
      bus.start = 1'b0;
      bus.ALUC  = 4'b0000;
      bus.A     = '0;
      bus.B     = '0;
      rst       = 1'b1;
      tick();
      tick();
      rst       = 1'b0;
      expResult = '0;
      expZero   = 1'b1;
      expHi     = '0;
      expLo     = '0;
      checkOutput("reset.result", 64'(bus.result), 64'(0));
      checkOutput("reset.zero",   64'(bus.zero),   64'(1));
      checkOutput("reset.hilo",   {bus.hi, bus.lo}, 64'(0));
      checkOutput("reset.busy",   64'(bus.busy),   64'(0));
      checkOutput("reset.done",   64'(bus.done),   64'(0));

      applyStimulus(4'b0100, 32'h7FFF_FFFF, 32'h0000_0001);
      checkOutput("add.value", 64'(bus.result), 64'h8000_0000);
      idleCycle();

      applyStimulus(4'b0101, 32'h0000_1234, 32'h0000_1234);
      applyStimulus(4'b0111, 32'hFFFF_FFFF, 32'h0000_0001);
      checkOutput("slt.value", 64'(bus.result), 64'(1));
      idleCycle();

      runMult(32'hFFFF_FFFD, 32'h0000_0007, -1, -1);
      checkOutput("mult.neg3x7", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
      idleCycle();
      runMult(32'h8000_0000, 32'h8000_0000, -1, -1);
      checkOutput("mult.minxmin", {bus.hi, bus.lo}, 64'h4000_0000_0000_0000);
      idleCycle();

      runMult(32'd5, 32'd6, 10, -1);
      checkOutput("mult.5x6", {bus.hi, bus.lo}, 64'd30);
      idleCycle();

      runMult(32'd9, 32'd11, -1, 10);
      applyStimulus(4'b0100, 32'd20, 32'd22);
      idleCycle();

      for (int n = 0; n < 30; n++) begin
         op = opTable[$urandom_range(0, 7)];
         if (op == 4'b1010)
            runMult($urandom, $urandom, -1, -1);
         else
            applyStimulus(op, $urandom, ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom);
         if ($urandom_range(0, 1) == 1) idleCycle();
      end
      idleCycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_exec.md
Name: alu_exec

Overview:
- Execute stage of the MIPS datapath, directly downstream of the ALU control decoder.
- Consumes the 4-bit ALUC code and operands A/B, and produces a registered result, a zero flag and, for multiply, HI/LO.
- Single-cycle ops complete one cycle after start. Signed MULT runs a 32-iteration shift-add sequence behind a start/busy/done handshake.

Parameters:
- WIDTH, 32, operand/result width. MULT produces 2*WIDTH bits.
- ITER, WIDTH, number of multiply iterations. Must equal WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- ALUC  input  4  operation code from ALU control
- A  input  WIDTH  operand A (rs)
- B  input  WIDTH  operand B (rt/immediate)
- result  output  WIDTH  registered result
- zero  output  1  registered, (result == 0)
- hi  output  WIDTH  upper product word
- lo  output  WIDTH  lower product word
- busy  output  1  high while multiply iterates
- done  output  1  one-cycle completion pulse

Behaviour:
- Reset: one clock edge with rst=1 forces IDLE. result=0, zero=1, hi=0, lo=0, busy=0, done=0, iteration counter=0. rst has priority over every other event.
- ALUC decode (all other codes: result=0, zero=1, done pulses as a single-cycle op):
  - 0000 AND
  - 0011 OR
  - 0100 ADD
  - 0101 SUB
  - 0111 SLT
  - 1010 MULT
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH; no overflow flag or trap.
  - SLT is a signed compare: result = {WIDTH-1 zeros, (A<B signed)}.
- States: IDLE, MUL.
- IDLE with start=1 and a non-MULT code:
  - At that edge, result/zero are written and done=1 for the following cycle.
  - State stays IDLE; latency is 1 cycle.
  - hi/lo are unchanged.
- IDLE with start=1 and ALUC=1010:
  - Latch |A| and |B| as unsigned magnitudes (|0x80000000| = 0x80000000).
  - Latch sign = A[msb]^B[msb], clear the 2*WIDTH accumulator, set counter=ITER, go to MUL.
  - busy=1 from the next cycle.
- MUL, each edge:
  - If multiplier LSB=1, accumulator += multiplicand shifted by the iteration index (or an equivalent right-shift form).
  - Shift the multiplier right; decrement the counter.
- MUL, on the edge where the counter goes 1->0:
  - Write {hi,lo} = sign ? two's-complement negation of the accumulator : accumulator.
  - Set busy=0 and done=1 for the next cycle; return to IDLE.
  - result/zero are unchanged by MULT.
- MULT timing: accepted at edge E0; busy high for exactly ITER cycles; hi/lo valid and done=1 in the cycle after edge E_ITER.
- start while busy=1: ignored, with no queuing. Operands may change freely during MUL; only the values latched at E0 are used.
- start=1 in the same cycle done=1 (state is IDLE): accepted normally, giving back-to-back operations.
- done is never high in two consecutive cycles unless back-to-back single-cycle ops are issued.
- Reset during MUL: abort. Accumulator is discarded; hi/lo are reset to 0, not left partially updated.
- busy and done are never high simultaneously.

Test Plan:
- Reset: hold rst 2 cycles -> result=0, zero=1, hi=lo=0, busy=0, done=0.
- ADD: A=0x7FFFFFFF, B=1, ALUC=0100, start 1 cycle -> next cycle result=0x80000000, zero=0, done=1 for exactly 1 cycle.
- SUB equal, then SLT:
  - SUB A=B=0x1234 -> result=0, zero=1.
  - Then SLT A=0xFFFFFFFF, B=1 issued back-to-back -> result=1, zero=0, two consecutive done pulses.
- Signed MULT:
  - A=0xFFFFFFFD (-3), B=7 -> busy high 32 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFEB, done=1.
  - A=B=0x80000000 -> hi=0x40000000, lo=0.
- start ignored while busy: during a MULT of 5*6, pulse start with ALUC=0100 mid-sequence -> no early done, result unchanged, hi=0, lo=30 after 32 cycles.
- Reset mid-MULT: assert rst at iteration 10 -> next cycle busy=0, done=0, hi=lo=0, state IDLE. A new ADD then completes normally.
